// File: rtl/reg_multimode.sv
// Multi-mode data register: load, step up/down (wrap or saturate) and serial shift,
// with a combinational terminal-count flag and a registered one-cycle overflow pulse.
module reg_multimode #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode_sel,
    input  logic             mode_wr,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       mode,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_LOAD  = 2'b00,
        MODE_INC   = 2'b01,
        MODE_DEC   = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum, diff;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        sum    = {1'b0, out_q} + {1'b0, STEP_W};
        diff   = {1'b0, out_q} - {1'b0, STEP_W};
        mode_d = mode_q;
        out_d  = out_q;
        ovf_d  = 1'b0;

        if (mode_wr) begin
            mode_d = mode_e'(mode_sel);
        end

        // The operation always follows the registered mode, never mode_sel.
        if (clr) begin
            out_d = '0;
        end else if (en) begin
            unique case (mode_q)
                MODE_LOAD: begin
                    out_d = in;
                end
                MODE_INC: begin
                    ovf_d = sum[WIDTH];
                    out_d = (sum[WIDTH] && SATURATE) ? ALL_ONES : sum[WIDTH-1:0];
                end
                MODE_DEC: begin
                    // diff[WIDTH] is the borrow out of the unsigned subtraction.
                    ovf_d = diff[WIDTH];
                    out_d = (diff[WIDTH] && SATURATE) ? '0 : diff[WIDTH-1:0];
                end
                MODE_SHIFT: begin
                    ovf_d = out_q[WIDTH-1];
                    out_d = {out_q[WIDTH-2:0], in[0]};
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_LOAD;
            out_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            out_q  <= out_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out  = out_q;
    assign mode = mode_q;
    assign ovf  = ovf_q;
    assign tc   = ((mode_q == MODE_INC) && (out_q == ALL_ONES)) ||
                  ((mode_q == MODE_DEC) && (out_q == '0));

endmodule

// File: tb/tb_reg_multimode.sv
// Bench for reg_multimode: three parameterisations share one stimulus stream; an arithmetic
// reference model fills a scoreboard queue that a separate monitor drains every cycle.
module tb_reg_multimode;

    localparam int N = 3;

    typedef struct packed {
        logic [2:0][7:0] out;
        logic [2:0][1:0] mode;
        logic [2:0]      ovf;
        logic [2:0]      tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_v;
    logic       en, clr, mode_wr;
    logic [1:0] mode_sel;

    logic [7:0] out_a, out_b;
    logic [3:0] out_c;
    logic [1:0] mode_a, mode_b, mode_c;
    logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

    logic [2:0][7:0] act_out;
    logic [2:0][1:0] act_mode;
    logic [2:0]      act_ovf, act_tc;

    exp_t sb_q[$];
    int   m_out[N];
    int   m_mode[N];
    int   m_ovf[N];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reg_multimode #(.WIDTH(8), .STEP(1), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .in(in_v), .en(en), .clr(clr), .mode_sel(mode_sel),
        .mode_wr(mode_wr), .out(out_a), .mode(mode_a), .tc(tc_a), .ovf(ovf_a));
    reg_multimode #(.WIDTH(8), .STEP(3), .SATURATE(1'b1)) u_b (
        .clk(clk), .rst(rst), .in(in_v), .en(en), .clr(clr), .mode_sel(mode_sel),
        .mode_wr(mode_wr), .out(out_b), .mode(mode_b), .tc(tc_b), .ovf(ovf_b));
    reg_multimode #(.WIDTH(4), .STEP(5), .SATURATE(1'b0)) u_c (
        .clk(clk), .rst(rst), .in(in_v[3:0]), .en(en), .clr(clr), .mode_sel(mode_sel),
        .mode_wr(mode_wr), .out(out_c), .mode(mode_c), .tc(tc_c), .ovf(ovf_c));

    assign act_out  = {{4'h0, out_c}, out_b, out_a};
    assign act_mode = {mode_c, mode_b, mode_a};
    assign act_ovf  = {ovf_c, ovf_b, ovf_a};
    assign act_tc   = {tc_c, tc_b, tc_a};

    function automatic int p_w(int i);
        return (i == 2) ? 4 : 8;
    endfunction

    function automatic int p_step(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 5);
    endfunction

    function automatic bit p_sat(int i);
        return (i == 1);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_out[i]  = 0;
            m_mode[i] = 0;
            m_ovf[i]  = 0;
        end
    endtask

    // Reference behaviour on plain integers: range test for carry/borrow, modulo for wrap.
    task automatic model_step(input int i, input int din, input bit e, input bit c,
                              input int sel, input bit wr);
        int mx   = (1 << p_w(i)) - 1;
        int stp  = p_step(i) & mx;
        int v    = 0;
        int nout = m_out[i];
        int novf = 0;
        if (c) begin
            nout = 0;
        end else if (e) begin
            case (m_mode[i])
                0: nout = din & mx;
                1: begin
                    v = m_out[i] + stp;
                    if (v > mx) begin
                        novf = 1;
                        nout = p_sat(i) ? mx : v - (mx + 1);
                    end else begin
                        nout = v;
                    end
                end
                2: begin
                    v = m_out[i] - stp;
                    if (v < 0) begin
                        novf = 1;
                        nout = p_sat(i) ? 0 : v + (mx + 1);
                    end else begin
                        nout = v;
                    end
                end
                default: begin
                    novf = (m_out[i] >> (p_w(i) - 1)) & 1;
                    nout = ((m_out[i] * 2) + (din & 1)) & mx;
                end
            endcase
        end
        m_out[i] = nout;
        m_ovf[i] = novf;
        if (wr) m_mode[i] = sel;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.out[i]  = 8'(m_out[i]);
            e.mode[i] = 2'(m_mode[i]);
            e.ovf[i]  = (m_ovf[i] != 0);
            e.tc[i]   = ((m_mode[i] == 1) && (m_out[i] == (1 << p_w(i)) - 1)) ||
                        ((m_mode[i] == 2) && (m_out[i] == 0));
        end
        return e;
    endfunction

    task automatic step(input logic [7:0] din, input bit e, input bit c,
                        input logic [1:0] sel, input bit wr);
        @(negedge clk);
        in_v     = din;
        en       = e;
        clr      = c;
        mode_sel = sel;
        mode_wr  = wr;
        for (int i = 0; i < N; i++) model_step(i, int'(din), e, c, int'(sel), wr);
        sb_q.push_back(snapshot());
    endtask

    task automatic idle();
        step(8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic check_reset_state(input string name);
        for (int i = 0; i < N; i++) begin
            check({name, "_out"}, i, 32'(act_out[i]), 32'h0);
            check({name, "_mode"}, i, 32'(act_mode[i]), 32'h0);
            check({name, "_ovf"}, i, 32'(act_ovf[i]), 32'h0);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check("out", i, 32'(act_out[i]), 32'(e.out[i]));
                    check("mode", i, 32'(act_mode[i]), 32'(e.mode[i]));
                    check("ovf", i, 32'(act_ovf[i]), 32'(e.ovf[i]));
                    check("tc", i, 32'(act_tc[i]), 32'(e.tc[i]));
                end
            end
        end
    end

    initial begin
        logic [7:0] din;
        rst = 1'b0; in_v = '0; en = 1'b0; clr = 1'b0; mode_sel = 2'b00; mode_wr = 1'b0;
        model_reset();
        #2;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b1;

        // Count up 5 times, then reset asynchronously between edges.
        step(8'h00, 1'b0, 1'b0, 2'b01, 1'b1);
        repeat (5) step(8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
        idle();
        @(posedge clk);
        #3;
        check("pre_rst_out_a", 0, 32'(out_a), 32'h05);
        rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        idle();

        // Load 0xFE, increment through the wrap point.
        step(8'hFE, 1'b1, 1'b0, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 2'b01, 1'b1);
        repeat (3) step(8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #2;
        check("wrap_out_a", 0, 32'(out_a), 32'h01);
        check("wrap_ovf_a", 0, 32'(ovf_a), 32'h0);

        // Saturating decrement from 0x04 by 3.
        step(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
        step(8'h04, 1'b1, 1'b0, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 2'b10, 1'b1);
        repeat (3) step(8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #2;
        check("satdec_out_b", 1, 32'(out_b), 32'h00);
        check("satdec_ovf_b", 1, 32'(ovf_b), 32'h1);
        check("satdec_tc_b", 1, 32'(tc_b), 32'h1);

        // mode_wr together with en: op uses the old mode.
        step(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
        step(8'h10, 1'b1, 1'b0, 2'b00, 1'b0);
        step(8'h55, 1'b1, 1'b0, 2'b01, 1'b1);
        step(8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #2;
        check("modewr_out_a", 0, 32'(out_a), 32'h56);

        // Shift 0b1001 with serial inputs 1 then 0.
        step(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
        step(8'h09, 1'b1, 1'b0, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 2'b11, 1'b1);
        step(8'h01, 1'b1, 1'b0, 2'b00, 1'b0);
        step(8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #2;
        check("shift_out_c", 2, 32'(out_c), 32'h6);

        // clr wins over en.
        step(8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
        step(8'h7F, 1'b1, 1'b0, 2'b00, 1'b0);
        step(8'h00, 1'b0, 1'b0, 2'b01, 1'b1);
        step(8'h00, 1'b1, 1'b1, 2'b00, 1'b0);
        idle();
        @(posedge clk); #2;
        check("clr_out_a", 0, 32'(out_a), 32'h00);

        // Randomised traffic, biased towards boundary load values.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: din = 8'hFF;
                1: din = 8'h00;
                2: din = 8'h02;
                default: din = 8'($urandom);
            endcase
            step(din, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
        end
        idle();

        @(posedge clk); #2;
        check("sb_drain", 0, 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
